// File: rtl/pe_group_sched.sv
// ============================================================================
// pe_group_sched -- per-job tile/beat sequencer for a PE group   (rev 1.0)
// ============================================================================
`default_nettype none

module pe_group_sched #(
  parameter int DRAIN_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [3:0]  layer_cfg,
  input  logic [9:0]  beat_cfg,
  input  logic [7:0]  tile_cfg,
  input  logic        wb_en,
  output logic [2:0]  process,
  output logic [3:0]  layer,
  output logic [15:0] rd_addr,
  output logic [7:0]  tile_idx,
  output logic        finish_flag,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int DW = $clog2(DRAIN_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    layer_q, layer_d;
  logic [9:0]    beats_q, beats_d;
  logic [7:0]    tiles_q, tiles_d;
  logic [15:0]   rd_addr_q, rd_addr_d;
  logic [7:0]    tile_q, tile_d;
  logic [9:0]    beat_ctr_q, beat_ctr_d;
  logic [10:0]   wb_ctr_q, wb_ctr_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          err_q, err_d;

  logic          cfg_ok;
  logic [10:0]   wb_total;
  logic          wb_reached;

  assign cfg_ok = ((layer_cfg == 4'd1) || (layer_cfg == 4'd3) ||
                   (layer_cfg == 4'd4) || (layer_cfg == 4'd5)) &&
                  (beat_cfg != 10'd0) && (tile_cfg != 8'd0);

  // Write-backs landing in the current cycle count toward the drain exit.
  assign wb_total   = wb_ctr_q + {10'd0, wb_en};
  assign wb_reached = (wb_total >= {1'b0, beats_q});

  always_comb begin
    state_d    = state_q;
    layer_d    = layer_q;
    beats_d    = beats_q;
    tiles_d    = tiles_q;
    rd_addr_d  = rd_addr_q;
    tile_d     = tile_q;
    beat_ctr_d = beat_ctr_q;
    wb_ctr_d   = wb_ctr_q;
    drain_d    = drain_q;
    err_d      = 1'b0;

    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      rd_addr_d  = 16'd0;
      tile_d     = 8'd0;
      beat_ctr_d = 10'd0;
      wb_ctr_d   = 11'd0;
      drain_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            if (cfg_ok) begin
              layer_d    = layer_cfg;
              beats_d    = beat_cfg;
              tiles_d    = tile_cfg;
              rd_addr_d  = 16'd0;
              tile_d     = 8'd0;
              beat_ctr_d = 10'd0;
              wb_ctr_d   = 11'd0;
              drain_d    = '0;
              state_d    = S_INIT;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_INIT: begin
          beat_ctr_d = 10'd0;
          wb_ctr_d   = 11'd0;
          drain_d    = '0;
          state_d    = S_RUN;
        end
        S_RUN: begin
          rd_addr_d  = rd_addr_q + 16'd1;
          beat_ctr_d = beat_ctr_q + 10'd1;
          wb_ctr_d   = wb_total;
          if (beat_ctr_q == beats_q - 10'd1) begin
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          wb_ctr_d = wb_total;
          drain_d  = drain_q + DW'(1);
          if (wb_reached || (drain_q == DW'(DRAIN_MAX - 1))) begin
            err_d = !wb_reached;
            if (tile_q < tiles_q - 8'd1) begin
              tile_d  = tile_q + 8'd1;
              state_d = S_INIT;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      layer_q    <= 4'd0;
      beats_q    <= 10'd0;
      tiles_q    <= 8'd0;
      rd_addr_q  <= 16'd0;
      tile_q     <= 8'd0;
      beat_ctr_q <= 10'd0;
      wb_ctr_q   <= 11'd0;
      drain_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      layer_q    <= layer_d;
      beats_q    <= beats_d;
      tiles_q    <= tiles_d;
      rd_addr_q  <= rd_addr_d;
      tile_q     <= tile_d;
      beat_ctr_q <= beat_ctr_d;
      wb_ctr_q   <= wb_ctr_d;
      drain_q    <= drain_d;
      err_q      <= err_d;
    end
  end

  assign process     = state_q;
  assign layer       = layer_q;
  assign rd_addr     = rd_addr_q;
  assign tile_idx    = tile_q;
  assign finish_flag = (state_q == S_DRAIN);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign err         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pe_group_sched.sv
// ============================================================================
// tb_pe_group_sched -- directed self-checking bench for pe_group_sched (rev 1.0)
// ============================================================================
`default_nettype none

module tb_pe_group_sched;

  logic        clk = 1'b0;
  logic        rst, start, abort, wb_en;
  logic [3:0]  layer_cfg;
  logic [9:0]  beat_cfg;
  logic [7:0]  tile_cfg;
  logic [2:0]  process;
  logic [3:0]  layer;
  logic [15:0] rd_addr;
  logic [7:0]  tile_idx;
  logic        finish_flag, busy, done, err;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic wb_mode = 1'b0;
  logic [3:0] pipe = 4'd0;

  pe_group_sched #(.DRAIN_MAX(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .layer_cfg(layer_cfg), .beat_cfg(beat_cfg), .tile_cfg(tile_cfg),
    .wb_en(wb_en), .process(process), .layer(layer), .rd_addr(rd_addr),
    .tile_idx(tile_idx), .finish_flag(finish_flag), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // PE group model: write-back returns 3 cycles after each RUN beat.
  task automatic step();
    @(posedge clk);
    #1;
    pipe  = {pipe[2:0], (process == 3'd2)};
    wb_en = wb_mode ? pipe[3] : 1'b0;
  endtask

  task automatic go(input logic [3:0] l, input logic [9:0] b, input logic [7:0] t);
    layer_cfg = l; beat_cfg = b; tile_cfg = t; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; abort = 1'b0; wb_en = 1'b0;
    layer_cfg = 4'd0; beat_cfg = 10'd0; tile_cfg = 8'd0;
    #3;
    n_cmp++;
    if ({process, layer, rd_addr, tile_idx, finish_flag, busy, done, err} !== 36'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {process, layer, rd_addr, tile_idx, finish_flag, busy, done, err});
    end
    step(); step();
    rst = 1'b1;
    step();
    n_cmp++;
    if ({process, busy} !== 4'd0) begin
      n_bad++; $display("FAIL reset_release_idle: got process=%0d busy=%0b want 0/0", process, busy);
    end
  endtask

  task automatic test_single();
    int exp_p [10] = '{1, 2, 2, 2, 2, 3, 3, 3, 4, 0};
    int dc = 0;
    int ec = 0;
    wb_mode = 1'b1; pipe = 4'd0;
    go(4'd1, 10'd4, 8'd1);
    for (int i = 0; i < 10; i++) begin
      if (i != 0) step();
      dc += int'(done);
      ec += int'(err);
      n_cmp++;
      if ({process, finish_flag, busy} !== {exp_p[i][2:0], exp_p[i] == 3, exp_p[i] != 0}) begin
        n_bad++;
        $display("FAIL single_seq[%0d]: got process=%0d ff=%0b busy=%0b want process=%0d",
                 i, process, finish_flag, busy, exp_p[i]);
      end
    end
    n_cmp++;
    if (rd_addr !== 16'd4) begin n_bad++; $display("FAIL single_rd_addr: got %0d want 4", rd_addr); end
    n_cmp++;
    if (dc != 1) begin n_bad++; $display("FAIL single_done_count: got %0d want 1", dc); end
    n_cmp++;
    if (ec != 0 || layer !== 4'd1) begin
      n_bad++; $display("FAIL single_err_layer: got err_count=%0d layer=%0d want 0/1", ec, layer);
    end
  endtask

  task automatic test_tiles();
    int exp_p [20] = '{1,2,2,3,3,3, 1,2,2,3,3,3, 1,2,2,3,3,3, 4,0};
    int exp_t [20] = '{0,0,0,0,0,0, 1,1,1,1,1,1, 2,2,2,2,2,2, 2,2};
    int dc = 0;
    wb_mode = 1'b1; pipe = 4'd0;
    go(4'd3, 10'd2, 8'd3);
    for (int i = 0; i < 20; i++) begin
      if (i != 0) step();
      dc += int'(done);
      n_cmp++;
      if (process !== exp_p[i][2:0] || tile_idx !== exp_t[i][7:0] || err !== 1'b0) begin
        n_bad++;
        $display("FAIL tiles_seq[%0d]: got process=%0d tile=%0d err=%0b want %0d/%0d/0",
                 i, process, tile_idx, err, exp_p[i], exp_t[i]);
      end
    end
    n_cmp++;
    if (rd_addr !== 16'd6) begin n_bad++; $display("FAIL tiles_rd_addr: got %0d want 6", rd_addr); end
    n_cmp++;
    if (dc != 1) begin n_bad++; $display("FAIL tiles_done_count: got %0d want 1", dc); end
  endtask

  task automatic test_bad_cfg();
    go(4'd2, 10'd2, 8'd1);
    n_cmp++;
    if ({err, busy, process, layer} !== {1'b1, 1'b0, 3'd0, 4'd3}) begin
      n_bad++; $display("FAIL bad_layer: got err=%0b busy=%0b process=%0d layer=%0d want 1/0/0/3",
                        err, busy, process, layer);
    end
    step();
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL bad_err_width: got err=%0b want 0", err); end
    go(4'd1, 10'd0, 8'd1);
    n_cmp++;
    if ({err, busy, process, layer, rd_addr} !== {1'b1, 1'b0, 3'd0, 4'd3, 16'd6}) begin
      n_bad++; $display("FAIL bad_beat: got err=%0b busy=%0b process=%0d layer=%0d rd=%0d want 1/0/0/3/6",
                        err, busy, process, layer, rd_addr);
    end
    go(4'd4, 10'd3, 8'd0);
    n_cmp++;
    if ({err, busy} !== 2'b10) begin
      n_bad++; $display("FAIL bad_tile: got err=%0b busy=%0b want 1/0", err, busy);
    end
    step();
  endtask

  task automatic test_drain_timeout();
    int exp_p [9] = '{1, 2, 2, 3, 3, 3, 3, 4, 0};
    wb_mode = 1'b0;
    go(4'd4, 10'd2, 8'd1);
    for (int i = 0; i < 9; i++) begin
      if (i != 0) step();
      n_cmp++;
      if (process !== exp_p[i][2:0] || err !== (i == 7)) begin
        n_bad++;
        $display("FAIL timeout_seq[%0d]: got process=%0d err=%0b want %0d/%0b",
                 i, process, err, exp_p[i], (i == 7));
      end
    end
  endtask

  task automatic test_abort();
    int dc = 0;
    wb_mode = 1'b1; pipe = 4'd0;
    go(4'd5, 10'd4, 8'd1);
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_cmp++;
    if ({process, busy, finish_flag, done} !== 6'd0) begin
      n_bad++; $display("FAIL abort_idle: got process=%0d busy=%0b ff=%0b done=%0b want 0",
                        process, busy, finish_flag, done);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      dc += int'(done);
    end
    n_cmp++;
    if (dc != 0) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses want 0", dc); end
    go(4'd1, 10'd4, 8'd1);
    n_cmp++;
    if ({process, rd_addr} !== {3'd1, 16'd0}) begin
      n_bad++; $display("FAIL abort_restart: got process=%0d rd=%0d want 1/0", process, rd_addr);
    end
    for (int i = 0; i < 9; i++) begin
      step();
      dc += int'(done);
    end
    n_cmp++;
    if (rd_addr !== 16'd4 || dc != 1 || process !== 3'd0) begin
      n_bad++; $display("FAIL abort_rerun: got rd=%0d done=%0d process=%0d want 4/1/0", rd_addr, dc, process);
    end
  endtask

  task automatic test_abort_priority();
    abort = 1'b1;
    go(4'd1, 10'd4, 8'd1);
    abort = 1'b0;
    n_cmp++;
    if ({process, busy, err} !== 5'd0) begin
      n_bad++; $display("FAIL abort_priority: got process=%0d busy=%0b err=%0b want 0", process, busy, err);
    end
    step();
  endtask

  task automatic test_wrap();
    logic [15:0] prev = 16'd0;
    logic seen_fe = 1'b0;
    logic wrapped = 1'b0;
    int ec = 0;
    wb_mode = 1'b1; pipe = 4'd0;
    go(4'd1, 10'd1023, 8'd65);
    for (int k = 0; k < 70000; k++) begin
      step();
      ec += int'(err);
      if (rd_addr == 16'hFFFE) seen_fe = 1'b1;
      if (prev == 16'hFFFF && rd_addr == 16'h0000) begin
        wrapped = 1'b1;
        break;
      end
      prev = rd_addr;
    end
    n_cmp++;
    if (!seen_fe || !wrapped) begin
      n_bad++; $display("FAIL wrap_addr: got seen_fffe=%0b wrapped=%0b rd=%h want 1/1", seen_fe, wrapped, rd_addr);
    end
    n_cmp++;
    if (ec != 0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL wrap_no_err: got err_count=%0d busy=%0b want 0/1", ec, busy);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_cmp++;
    if (process !== 3'd0) begin n_bad++; $display("FAIL wrap_abort: got process=%0d want 0", process); end
  endtask

  task automatic test_reset_in_drain();
    logic got = 1'b0;
    wb_mode = 1'b0;
    go(4'd3, 10'd2, 8'd1);
    for (int k = 0; k < 10; k++) begin
      if (process == 3'd3) begin
        got = 1'b1;
        break;
      end
      step();
    end
    n_cmp++;
    if (!got || finish_flag !== 1'b1) begin
      n_bad++; $display("FAIL drain_reach: got reached=%0b ff=%0b want 1/1", got, finish_flag);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({process, layer, rd_addr, tile_idx, finish_flag, busy, done, err} !== 36'd0) begin
      n_bad++;
      $display("FAIL rst_in_drain: got %h want 0",
               {process, layer, rd_addr, tile_idx, finish_flag, busy, done, err});
    end
    #3 rst = 1'b1;
    step();
    n_cmp++;
    if ({process, busy, finish_flag} !== 5'd0) begin
      n_bad++; $display("FAIL rst_release: got process=%0d busy=%0b ff=%0b want 0", process, busy, finish_flag);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tiles();
    test_bad_cfg();
    test_drain_timeout();
    test_abort();
    test_abort_priority();
    test_wrap();
    test_reset_in_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
